pkt_tx_framer: RTL and testbench
================================

Name: pkt_tx_framer

Overview:
- Single-channel store-and-forward packet transmitter. It drives one channel's ingress bus of the 8-channel packet switch top (chN_data_in / sop / eop / qos / id).
- The ingress bus has no valid and no backpressure, so every packet must leave as a contiguous sop..eop burst. The block therefore buffers the whole payload before it emits the first byte.
- Eight instances form the traffic source in front of the switch.

Parameters:
- DATA_W, 8, payload byte width.
- ID_W, 3, destination id width.
- MAX_LEN, 64, maximum packet length in bytes (buffer depth).
- LEN_W, 7, width of the length field; must hold MAX_LEN.
- GAP, 1, number of forced idle cycles after eop (0 allowed).
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- desc_valid  in  1  packet descriptor valid.
- desc_ready  out  1  descriptor accepted when desc_valid and desc_ready are both 1 at a clock edge.
- desc_len  in  LEN_W  packet length in bytes; legal range 1..MAX_LEN.
- desc_qos  in  1  qos bit for the packet.
- desc_id  in  ID_W  destination id for the packet.
- pay_valid  in  1  payload byte valid.
- pay_ready  out  1  payload byte accepted when pay_valid and pay_ready are both 1 at a clock edge.
- pay_data  in  DATA_W  payload byte.
- tx_data  out  DATA_W  byte toward the switch ingress.
- tx_sop  out  1  first byte of the packet.
- tx_eop  out  1  last byte of the packet.
- tx_qos  out  1  qos, held for every byte of the packet.
- tx_id  out  ID_W  id, held for every byte of the packet.
- tx_busy  out  1  high in LOAD, SEND and GAP.
- pkt_sent  out  1  one-cycle pulse, coincident with tx_eop.
- pkt_cnt  out  CNT_W  count of packets sent.
- err_len  out  1  one-cycle pulse when an illegal descriptor is dropped.

Behaviour:
- Reset: state IDLE.
  - All tx_* outputs 0; pkt_sent 0, err_len 0, tx_busy 0, pkt_cnt 0.
  - desc_ready 1 after reset; pay_ready 0.
  - Buffer contents are don't-care.
- All tx_*, pkt_sent and err_len are registered. Outside SEND, tx_data, tx_sop, tx_eop, tx_qos and tx_id are all 0.
- State IDLE:
  - desc_ready = 1.
  - On acceptance with a legal length, latch len/qos/id, clear the write pointer, and go to LOAD.
  - On acceptance with desc_len = 0 or desc_len > MAX_LEN: the descriptor is consumed, err_len pulses in the next cycle, and the state stays IDLE. No payload is consumed.
- State LOAD:
  - pay_ready = 1 and desc_ready = 0.
  - Each accepted byte is written to buffer[wptr] and wptr increments.
  - pay_valid gaps stall LOAD indefinitely with no timeout.
  - After the len-th byte is accepted, go to SEND.
- State SEND:
  - The first byte (tx_sop = 1) appears in the cycle immediately after the edge that accepted the last payload byte.
  - That holds for len = 1 as well; a write-to-read bypass is required.
  - Exactly len consecutive cycles, bytes in acceptance order.
  - tx_sop on byte 0, tx_eop on byte len-1. For len = 1, sop and eop are high in the same cycle.
  - tx_qos and tx_id are constant for all len cycles.
  - pay_ready = 0 and desc_ready = 0.
- State GAP:
  - GAP idle cycles with all tx outputs 0, then IDLE. With GAP = 0, SEND goes directly to IDLE.
  - The next sop can therefore never be adjacent to an eop unless GAP = 0; even then, IDLE and LOAD add at least 2 cycles.
- pkt_cnt increments on the edge ending the eop cycle. It wraps from 2^CNT_W-1 to 0. Dropped descriptors never count.
- rst asserted in any state, including mid-LOAD or mid-SEND:
  - The next cycle is the reset state and the partial packet is discarded.
  - No eop is emitted for a truncated packet.
  - pkt_cnt returns to 0.
- desc_valid and pay_valid outside their ready windows are ignored; there is no internal queueing.

Test Plan:
- Reset, then descriptor len=4, qos=1, id=5, then bytes A0,A1,A2,A3 back-to-back -> the cycle after A3 is accepted, tx_data = A0,A1,A2,A3 on 4 consecutive cycles. tx_sop only on A0; tx_eop and pkt_sent only on A3. qos=1 and id=5 on all four bytes; all tx outputs 0 afterwards; pkt_cnt = 1.
- Descriptor len=1, id=2, byte 5A -> a single cycle with tx_data=5A, sop=1, eop=1, id=2; pkt_cnt increments by 1.
- Descriptors len=0, then len=65 (MAX_LEN=64) -> each gives err_len for one cycle. pay_ready stays 0, no tx activity, pkt_cnt unchanged, desc_ready stays 1.
- Descriptor len=8 with pay_valid toggling 1,0,0,1,... during LOAD -> output is still 8 contiguous cycles with the correct byte order and no holes between sop and eop.
- Two descriptors (len=3 then len=2) with GAP=1 -> desc_ready is 0 through SEND and GAP. At least 1 all-zero cycle separates the first eop from the second sop; pkt_cnt = 2.
- rst pulsed during the 3rd byte of a len=8 SEND -> the next cycle has all tx outputs 0, pkt_cnt=0, desc_ready=1, and no eop is ever emitted. A following len=2 packet transmits correctly.

Source files
------------

// File: rtl/pkt_tx_framer.sv
// Store-and-forward packet transmitter: buffers a whole payload, then emits it
// as one contiguous sop..eop burst on a valid-less switch ingress bus.
module pkt_tx_framer #(
  parameter int DATA_W  = 8,
  parameter int ID_W    = 3,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int GAP     = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              desc_qos,
  input  logic [ID_W-1:0]   desc_id,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [DATA_W-1:0] pay_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              tx_qos,
  output logic [ID_W-1:0]   tx_id,
  output logic              tx_busy,
  output logic              pkt_sent,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              err_len
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [MAX_LEN];
  logic [LEN_W-1:0]  len_q, wptr, rptr, rnxt;
  logic              qos_q;
  logic [ID_W-1:0]   id_q;
  logic [GW-1:0]     gcnt;
  logic              len_ok, desc_acc, pay_acc, last_wr, last_rd;
  logic [DATA_W-1:0] first_byte;

  assign len_ok   = (desc_len != '0) && (desc_len <= LEN_W'(MAX_LEN));
  assign desc_acc = desc_valid && desc_ready;
  assign pay_acc  = pay_valid && pay_ready;
  assign last_wr  = (wptr == len_q - LEN_W'(1));
  assign last_rd  = (rptr == len_q - LEN_W'(1));
  assign rnxt     = rptr + LEN_W'(1);
  // len=1: byte 0 is being written on the same edge it must be launched
  assign first_byte = (wptr == '0) ? pay_data : mem[0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (desc_acc && len_ok) state_nxt = S_LOAD;
      S_LOAD: if (pay_acc && last_wr) state_nxt = S_SEND;
      S_SEND: if (last_rd)            state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gcnt == GW'(GAP - 1)) state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    desc_ready = (state == S_IDLE);
    pay_ready  = (state == S_LOAD);
    tx_busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (pay_acc) mem[wptr[AW-1:0]] <= pay_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      qos_q    <= 1'b0;
      id_q     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      gcnt     <= '0;
      tx_data  <= '0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_qos   <= 1'b0;
      tx_id    <= '0;
      pkt_sent <= 1'b0;
      pkt_cnt  <= '0;
      err_len  <= 1'b0;
    end else begin
      err_len <= desc_acc && !len_ok;
      case (state)
        S_IDLE: if (desc_acc && len_ok) begin
          len_q <= desc_len;
          qos_q <= desc_qos;
          id_q  <= desc_id;
          wptr  <= '0;
        end
        S_LOAD: if (pay_acc) begin
          wptr <= wptr + LEN_W'(1);
          if (last_wr) begin
            rptr     <= '0;
            tx_data  <= first_byte;
            tx_sop   <= 1'b1;
            tx_eop   <= (len_q == LEN_W'(1));
            pkt_sent <= (len_q == LEN_W'(1));
            tx_qos   <= qos_q;
            tx_id    <= id_q;
          end
        end
        S_SEND: begin
          if (last_rd) begin
            tx_data  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            tx_qos   <= 1'b0;
            tx_id    <= '0;
            pkt_sent <= 1'b0;
            pkt_cnt  <= pkt_cnt + CNT_W'(1);
            gcnt     <= '0;
          end else begin
            rptr     <= rnxt;
            tx_data  <= mem[rnxt[AW-1:0]];
            tx_sop   <= 1'b0;
            tx_eop   <= (rnxt == len_q - LEN_W'(1));
            pkt_sent <= (rnxt == len_q - LEN_W'(1));
          end
        end
        S_GAP: gcnt <= gcnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Bench for pkt_tx_framer: directed vector table, hand-built reset/gap
// sequences and random packets checked against a byte-queue reference.
module tb_pkt_tx_framer;
  localparam int DATA_W = 8, ID_W = 3, MAX_LEN = 64, LEN_W = 7, GAP = 1, CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              desc_valid, desc_ready, desc_qos;
  logic [LEN_W-1:0]  desc_len;
  logic [ID_W-1:0]   desc_id;
  logic              pay_valid, pay_ready;
  logic [DATA_W-1:0] pay_data, tx_data;
  logic              tx_sop, tx_eop, tx_qos, tx_busy, pkt_sent, err_len;
  logic [ID_W-1:0]   tx_id;
  logic [CNT_W-1:0]  pkt_cnt;

  always #5 clk = ~clk;

  pkt_tx_framer #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
                  .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
    .desc_qos(desc_qos), .desc_id(desc_id),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_qos(tx_qos), .tx_id(tx_id),
    .tx_busy(tx_busy), .pkt_sent(pkt_sent), .pkt_cnt(pkt_cnt), .err_len(err_len)
  );

  typedef struct {
    int       len;
    bit       qos;
    int       id;
    int       mode;   // 0 back-to-back, 1 pattern 1,0,0,1.., 2 random idles
    bit [7:0] base;   // payload bytes are base, base+1, ...
    bit       err;    // expected: descriptor dropped with err_len
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int exp_cnt = 0;
  logic [7:0] pb [MAX_LEN];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tx_quiet(input string name);
    chk(name, {tx_data, tx_sop, tx_eop, tx_qos, tx_id, pkt_sent}, 32'd0);
  endtask

  task automatic run_pkt(input int len, input bit q, input int id, input int mode);
    int t, nid;
    t = 0;
    while (!desc_ready && t < 200) begin step(); t++; end
    chk("desc_ready_wait", 32'(desc_ready), 32'd1);
    desc_valid = 1'b1; desc_len = LEN_W'(len); desc_qos = q; desc_id = ID_W'(id);
    step();
    desc_valid = 1'b0;
    if (len == 0 || len > MAX_LEN) begin
      chk("err_len", 32'(err_len), 32'd1);
      chk("err_pay_ready", 32'(pay_ready), 32'd0);
      chk("err_desc_ready", 32'(desc_ready), 32'd1);
      tx_quiet("err_tx_quiet");
      step();
      chk("err_len_pulse", 32'(err_len), 32'd0);
      chk("err_cnt", 32'(pkt_cnt), 32'(exp_cnt & 16'hFFFF));
      return;
    end
    chk("no_err", 32'(err_len), 32'd0);
    chk("load_pay_ready", 32'(pay_ready), 32'd1);
    chk("load_desc_ready", 32'(desc_ready), 32'd0);
    exp_q = {};
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pb[i]);
      nid = (mode == 1) ? ((i == 0) ? 0 : 2) : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (nid) begin
        pay_valid = 1'b0; pay_data = 8'($urandom);
        step();
        tx_quiet("load_quiet");
      end
      pay_valid = 1'b1; pay_data = pb[i];
      step();
    end
    pay_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      chk("tx_sop", 32'(tx_sop), 32'(i == 0));
      chk("tx_eop", 32'(tx_eop), 32'(i == len - 1));
      chk("pkt_sent", 32'(pkt_sent), 32'(i == len - 1));
      chk("tx_qos_id", {tx_qos, tx_id}, {q, ID_W'(id)});
      chk("send_ready", {desc_ready, pay_ready, tx_busy}, 32'b001);
      chk("send_cnt", 32'(pkt_cnt), 32'(exp_cnt & 16'hFFFF));
      // stray handshakes while sending must be ignored
      desc_valid = 1'($urandom); desc_len = LEN_W'($urandom_range(1, 8));
      pay_valid = 1'($urandom); pay_data = 8'($urandom);
      step();
    end
    desc_valid = 1'b0; pay_valid = 1'b0;
    exp_cnt++;
    tx_quiet("gap_tx_quiet");
    chk("gap_cnt", 32'(pkt_cnt), 32'(exp_cnt & 16'hFFFF));
    chk("gap_ready", {desc_ready, pay_ready, tx_busy}, 32'b001);
    step();
    tx_quiet("idle_tx_quiet");
    chk("idle_ready", {desc_ready, pay_ready, tx_busy}, 32'b100);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{len: 4,   qos: 1'b1, id: 5, mode: 0, base: 8'hA0, err: 1'b0};
    vecs[1] = '{len: 1,   qos: 1'b0, id: 2, mode: 0, base: 8'h5A, err: 1'b0};
    vecs[2] = '{len: 0,   qos: 1'b1, id: 1, mode: 0, base: 8'h00, err: 1'b1};
    vecs[3] = '{len: 65,  qos: 1'b0, id: 3, mode: 0, base: 8'h00, err: 1'b1};
    vecs[4] = '{len: 8,   qos: 1'b1, id: 7, mode: 1, base: 8'h10, err: 1'b0};
    vecs[5] = '{len: 3,   qos: 1'b0, id: 4, mode: 0, base: 8'h30, err: 1'b0};
    vecs[6] = '{len: 2,   qos: 1'b1, id: 6, mode: 0, base: 8'h40, err: 1'b0};
    vecs[7] = '{len: 64,  qos: 1'b1, id: 0, mode: 0, base: 8'hC0, err: 1'b0};
    vecs[8] = '{len: 127, qos: 1'b0, id: 0, mode: 0, base: 8'h00, err: 1'b1};
    vecs[9] = '{len: 1,   qos: 1'b1, id: 7, mode: 2, base: 8'hFF, err: 1'b0};

    desc_valid = 1'b1; desc_len = 7'd4; desc_qos = 1'b1; desc_id = 3'd1;
    pay_valid = 1'b1; pay_data = 8'h77;
    rst = 1'b1;
    step(); step();
    chk("rst_ready", {desc_ready, pay_ready, tx_busy}, 32'b100);
    tx_quiet("rst_tx_quiet");
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    desc_valid = 1'b0; pay_valid = 1'b0;
    rst = 1'b0;
    step();

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < MAX_LEN; i++) pb[i] = vecs[v].base + 8'(i);
      run_pkt(vecs[v].len, vecs[v].qos, vecs[v].id, vecs[v].mode);
      chk("vec_err_expect", 32'(vecs[v].err), 32'(vecs[v].len == 0 || vecs[v].len > MAX_LEN));
    end

    // reset during the third byte of a len=8 send
    for (int i = 0; i < MAX_LEN; i++) pb[i] = 8'($urandom);
    desc_valid = 1'b1; desc_len = 7'd8; desc_qos = 1'b1; desc_id = 3'd3;
    step();
    desc_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin pay_valid = 1'b1; pay_data = pb[i]; step(); end
    pay_valid = 1'b0;
    step(); step();
    chk("mid_send_byte2", 32'(tx_data), 32'(pb[2]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    tx_quiet("rst_mid_tx_quiet");
    chk("rst_mid_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_mid_ready", {desc_ready, pay_ready, tx_busy}, 32'b100);
    for (int i = 0; i < 12; i++) begin
      chk("rst_no_eop", {tx_sop, tx_eop, pkt_sent}, 32'd0);
      step();
    end
    pb[0] = 8'h3C; pb[1] = 8'hC3;
    run_pkt(2, 1'b0, 1, 0);

    // random traffic, legal and illegal lengths
    for (int p = 0; p < 40; p++) begin
      int len, sel;
      sel = int'($urandom_range(0, 9));
      len = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(65, 127)) :
            int'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < MAX_LEN; i++) pb[i] = 8'($urandom);
      run_pkt(len, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
